// File: rtl/hex_record_tx.sv
// ---------------------------------------------------------------------------
// hex_record_tx
//
// Reads a block of bytes from a byte-wide synchronous memory and sends it
// as ASCII Intel HEX data records (type 00), one character per handshake.
// Long blocks are split into records of at most MAX_LEN data bytes.
//
// Optional feature (compile-time macro HEX_EOF_RECORD_EN):
//   defined   -> every transfer is closed with ":00000001FF" CR LF
//   undefined -> transfer ends after the last data record (LENGTH=0 sends
//                nothing and only pulses DONE)
//
// Ports
//   CLK        in   clock, rising edge
//   CLR        in   asynchronous reset, active high
//   START      in   one-cycle request, sampled only while BUSY=0
//   BASE_ADDR  in   [15:0] first memory address, captured with START
//   LENGTH     in   [15:0] number of bytes to send, captured with START
//   MEM_ADDR   out  [15:0] memory read address (holds between reads)
//   MEM_RD     out  read strobe, MEM_DATA valid in the following cycle
//   MEM_DATA   in   [7:0] memory read data
//   TX_DATA    out  [7:0] ASCII character
//   TX_VALID   out  TX_DATA holds a character
//   TX_READY   in   sink takes the character at this rising edge
//   BUSY       out  transfer in progress
//   DONE       out  one-cycle pulse at the end of a transfer
//   DBG_STATE  out  [4:0] current FSM state (observation only)
//
// Character handshake: a character transfers on a rising edge where
// TX_VALID=1 and TX_READY=1. While TX_VALID=1 and TX_READY=0 the character
// is held unchanged for as long as the sink stalls.
// ---------------------------------------------------------------------------
module hex_record_tx #(
   parameter int MAX_LEN = 16
) (
   input  logic        CLK,
   input  logic        CLR,
   input  logic        START,
   input  logic [15:0] BASE_ADDR,
   input  logic [15:0] LENGTH,
   output logic [15:0] MEM_ADDR,
   output logic        MEM_RD,
   input  logic [7:0]  MEM_DATA,
   output logic [7:0]  TX_DATA,
   output logic        TX_VALID,
   input  logic        TX_READY,
   output logic        BUSY,
   output logic        DONE,
   output logic [4:0]  DBG_STATE
);

`ifdef HEX_EOF_RECORD_EN
   localparam logic EOF_EN = 1'b1;
`else
   localparam logic EOF_EN = 1'b0;
`endif

   typedef enum logic [4:0] {
      IDLE  = 5'd0,  COLON = 5'd1,  CNTH = 5'd2,  CNTL = 5'd3,
      ADHH  = 5'd4,  ADHL  = 5'd5,  ADLH = 5'd6,  ADLL = 5'd7,
      TYH   = 5'd8,  TYL   = 5'd9,  RD   = 5'd10, LAT  = 5'd11,
      DH    = 5'd12, DL    = 5'd13, CKH  = 5'd14, CKL  = 5'd15,
      CR    = 5'd16, LF    = 5'd17, FIN  = 5'd18
   } state_t;

   state_t      state;
   logic [15:0] addr;         // next memory address to read
   logic [15:0] remaining;    // bytes not yet assigned to a record
   logic [15:0] rec_addr;     // address field of the current record
   logic [7:0]  rec_cnt;      // count field of the current record
   logic [7:0]  rec_left;     // data bytes still to send in this record
   logic [7:0]  data_byte;
   logic [7:0]  cksum;        // running sum of emitted fields
   logic        is_eof;       // current record is the end-of-file record
   logic        eof_pending;

   logic        hs;
   logic        nxt_eof;
   logic [7:0]  nxt_cnt;
   logic [7:0]  ck_neg;

   function automatic logic [7:0] hex_chr(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

   assign hs        = TX_VALID & TX_READY;
   // A record is opened when data remains or when only the EOF record is left.
   assign nxt_eof   = (remaining == 16'd0);
   assign nxt_cnt   = nxt_eof ? 8'd0 :
                      (remaining > 16'(MAX_LEN)) ? 8'(MAX_LEN) : remaining[7:0];
   assign ck_neg    = 8'd0 - cksum;
   assign DBG_STATE = state;

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         state       <= IDLE;
         addr        <= 16'h0000;
         remaining   <= 16'h0000;
         rec_addr    <= 16'h0000;
         rec_cnt     <= 8'h00;
         rec_left    <= 8'h00;
         data_byte   <= 8'h00;
         cksum       <= 8'h00;
         is_eof      <= 1'b0;
         eof_pending <= 1'b0;
         MEM_ADDR    <= 16'h0000;
         MEM_RD      <= 1'b0;
         TX_DATA     <= 8'h00;
         TX_VALID    <= 1'b0;
         BUSY        <= 1'b0;
         DONE        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               DONE <= 1'b0;
               if (START) begin
                  addr        <= BASE_ADDR;
                  remaining   <= LENGTH;
                  eof_pending <= EOF_EN;
                  BUSY        <= 1'b1;
                  state       <= (LENGTH == 16'd0 && !EOF_EN) ? FIN : COLON;
               end
            end
            COLON: begin
               if (!TX_VALID) begin
                  // First record after START: open it and present ':'.
                  rec_cnt   <= nxt_cnt;
                  rec_left  <= nxt_cnt;
                  rec_addr  <= nxt_eof ? 16'h0000 : addr;
                  is_eof    <= nxt_eof;
                  remaining <= remaining - {8'h00, nxt_cnt};
                  if (nxt_eof) eof_pending <= 1'b0;
                  TX_DATA   <= 8'h3A;
                  TX_VALID  <= 1'b1;
               end else if (hs) begin
                  cksum   <= rec_cnt;
                  TX_DATA <= hex_chr(rec_cnt[7:4]);
                  state   <= CNTH;
               end
            end
            CNTH: if (hs) begin
               TX_DATA <= hex_chr(rec_cnt[3:0]);
               state   <= CNTL;
            end
            CNTL: if (hs) begin
               cksum   <= cksum + rec_addr[15:8];
               TX_DATA <= hex_chr(rec_addr[15:12]);
               state   <= ADHH;
            end
            ADHH: if (hs) begin
               TX_DATA <= hex_chr(rec_addr[11:8]);
               state   <= ADHL;
            end
            ADHL: if (hs) begin
               cksum   <= cksum + rec_addr[7:0];
               TX_DATA <= hex_chr(rec_addr[7:4]);
               state   <= ADLH;
            end
            ADLH: if (hs) begin
               TX_DATA <= hex_chr(rec_addr[3:0]);
               state   <= ADLL;
            end
            ADLL: if (hs) begin
               cksum   <= cksum + {7'h00, is_eof};
               TX_DATA <= 8'h30;
               state   <= TYH;
            end
            TYH: if (hs) begin
               TX_DATA <= is_eof ? 8'h31 : 8'h30;
               state   <= TYL;
            end
            TYL: if (hs) begin
               if (rec_cnt != 8'd0) begin
                  TX_VALID <= 1'b0;
                  MEM_RD   <= 1'b1;
                  MEM_ADDR <= addr;
                  state    <= RD;
               end else begin
                  TX_DATA  <= hex_chr(ck_neg[7:4]);
                  state    <= CKH;
               end
            end
            RD: begin
               MEM_RD <= 1'b0;
               addr   <= addr + 16'd1;
               state  <= LAT;
            end
            LAT: begin
               data_byte <= MEM_DATA;
               cksum     <= cksum + MEM_DATA;
               TX_DATA   <= hex_chr(MEM_DATA[7:4]);
               TX_VALID  <= 1'b1;
               state     <= DH;
            end
            DH: if (hs) begin
               TX_DATA <= hex_chr(data_byte[3:0]);
               state   <= DL;
            end
            DL: if (hs) begin
               rec_left <= rec_left - 8'd1;
               if (rec_left != 8'd1) begin
                  TX_VALID <= 1'b0;
                  MEM_RD   <= 1'b1;
                  MEM_ADDR <= addr;
                  state    <= RD;
               end else begin
                  TX_DATA  <= hex_chr(ck_neg[7:4]);
                  state    <= CKH;
               end
            end
            CKH: if (hs) begin
               TX_DATA <= hex_chr(ck_neg[3:0]);
               state   <= CKL;
            end
            CKL: if (hs) begin
               TX_DATA <= 8'h0D;
               state   <= CR;
            end
            CR: if (hs) begin
               TX_DATA <= 8'h0A;
               state   <= LF;
            end
            LF: if (hs) begin
               if (remaining != 16'd0 || eof_pending) begin
                  // Next record follows without a gap.
                  rec_cnt   <= nxt_cnt;
                  rec_left  <= nxt_cnt;
                  rec_addr  <= nxt_eof ? 16'h0000 : addr;
                  is_eof    <= nxt_eof;
                  remaining <= remaining - {8'h00, nxt_cnt};
                  if (nxt_eof) eof_pending <= 1'b0;
                  TX_DATA   <= 8'h3A;
                  state     <= COLON;
               end else begin
                  TX_VALID  <= 1'b0;
                  state     <= FIN;
               end
            end
            FIN: begin
               BUSY  <= 1'b0;
               DONE  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hex_record_tx.sv
// ---------------------------------------------------------------------------
// tb_hex_record_tx
//
// Bench for hex_record_tx. A synchronous memory model answers MEM_RD, a
// character sink drives TX_READY (always ready, random, or a fixed stall
// window), and a monitor collects accepted characters and read addresses.
// The expected character stream is built from the record format rules.
// ---------------------------------------------------------------------------
module tb_hex_record_tx;

   localparam int MAX_LEN = 16;
`ifdef HEX_EOF_RECORD_EN
   localparam bit EOF_MODEL = 1'b1;
`else
   localparam bit EOF_MODEL = 1'b0;
`endif

   logic        CLK;
   logic        CLR;
   logic        START;
   logic [15:0] BASE_ADDR;
   logic [15:0] LENGTH;
   logic [15:0] MEM_ADDR;
   logic        MEM_RD;
   logic [7:0]  MEM_DATA;
   logic [7:0]  TX_DATA;
   logic        TX_VALID;
   logic        TX_READY;
   logic        BUSY;
   logic        DONE;
   logic [4:0]  DBG_STATE;

   hex_record_tx #(.MAX_LEN(MAX_LEN)) dut (
      .CLK(CLK), .CLR(CLR), .START(START), .BASE_ADDR(BASE_ADDR),
      .LENGTH(LENGTH), .MEM_ADDR(MEM_ADDR), .MEM_RD(MEM_RD),
      .MEM_DATA(MEM_DATA), .TX_DATA(TX_DATA), .TX_VALID(TX_VALID),
      .TX_READY(TX_READY), .BUSY(BUSY), .DONE(DONE), .DBG_STATE(DBG_STATE)
   );

   // ---------------- clock / reset ----------------
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // ---------------- scoreboard state ----------------
   int          tests  = 0;
   int          failed = 0;
   logic [7:0]  exp_q[$];
   logic [7:0]  got_q[$];
   logic [15:0] exp_addr_q[$];
   logic [15:0] got_addr_q[$];
   logic [7:0]  mem [0:65535];
   int          done_cnt;
   int          rmode;
   int          rcyc;
   bit          stall_pend;
   logic [7:0]  stall_data;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- memory model: data one cycle after MEM_RD ----------------
   initial MEM_DATA = 8'h00;
   always @(posedge CLK) if (MEM_RD) MEM_DATA <= mem[MEM_ADDR];

   // ---------------- sink ready driver ----------------
   initial begin
      TX_READY = 1'b0;
      forever begin
         @(posedge CLK);
         #1;
         rcyc++;
         case (rmode)
            0:       TX_READY = 1'b1;
            1:       TX_READY = 1'($urandom_range(0, 1));
            default: TX_READY = !(rcyc >= 6 && rcyc < 11);
         endcase
      end
   end

   // ---------------- monitor ----------------
   initial begin
      stall_pend = 1'b0;
      forever begin
         @(negedge CLK);
         if (CLR) begin
            stall_pend = 1'b0;
         end else begin
            if (stall_pend) begin
               chk("stall_valid", 32'(TX_VALID), 32'd1);
               chk("stall_data", 32'(TX_DATA), 32'(stall_data));
            end
            if (TX_VALID && TX_READY) got_q.push_back(TX_DATA);
            if (MEM_RD) got_addr_q.push_back(MEM_ADDR);
            if (DONE) begin
               done_cnt++;
               chk("busy_with_done", 32'(BUSY), 32'd0);
            end
            stall_pend = TX_VALID && !TX_READY;
            stall_data = TX_DATA;
         end
      end
   end

   // ---------------- reference model ----------------
   task automatic push_str(input string s);
      for (int i = 0; i < s.len(); i++) exp_q.push_back(8'(s[i]));
   endtask

   task automatic push_hex(input logic [7:0] b);
      string hs;
      hs = "0123456789ABCDEF";
      exp_q.push_back(8'(hs[int'(b[7:4])]));
      exp_q.push_back(8'(hs[int'(b[3:0])]));
   endtask

   task automatic build_exp(input logic [15:0] base, input int len);
      int pos;
      exp_q.delete();
      exp_addr_q.delete();
      pos = 0;
      for (int i = 0; i < len; i++) exp_addr_q.push_back(16'(base + i));
      while (pos < len) begin
         int          cnt;
         int          sum;
         logic [15:0] a;
         logic [7:0]  rec[$];
         cnt = (len - pos > MAX_LEN) ? MAX_LEN : len - pos;
         a   = 16'(base + pos);
         rec = {8'(cnt), a[15:8], a[7:0], 8'h00};
         for (int j = 0; j < cnt; j++) rec.push_back(mem[16'(a + j)]);
         sum = 0;
         foreach (rec[k]) sum += int'(rec[k]);
         rec.push_back(8'((256 - (sum % 256)) % 256));
         push_str(":");
         foreach (rec[k]) push_hex(rec[k]);
         exp_q.push_back(8'h0D);
         exp_q.push_back(8'h0A);
         pos += cnt;
      end
      if (EOF_MODEL) begin
         push_str(":00000001FF");
         exp_q.push_back(8'h0D);
         exp_q.push_back(8'h0A);
      end
   endtask

   // ---------------- driver: one complete transfer ----------------
   task automatic do_xfer(input string name, input logic [15:0] base,
                          input logic [15:0] len, input int mode);
      int n;
      build_exp(base, int'(len));
      got_q.delete();
      got_addr_q.delete();
      done_cnt = 0;
      rmode    = mode;
      @(negedge CLK);
      rcyc      = 0;
      START     = 1'b1;
      BASE_ADDR = base;
      LENGTH    = len;
      @(negedge CLK);
      START     = 1'b0;
      BASE_ADDR = 16'($urandom);
      LENGTH    = 16'($urandom);
      chk({name, "_busy_rise"}, 32'(BUSY), 32'd1);
      chk({name, "_no_char_yet"}, 32'(TX_VALID), 32'd0);
      @(negedge CLK);
      n = 2;
      if (exp_q.size() > 0) begin
         chk({name, "_colon_valid"}, 32'(TX_VALID), 32'd1);
         chk({name, "_colon_char"}, 32'(TX_DATA), 32'h3A);
      end
      while (!DONE && n < 5000) begin
         @(negedge CLK);
         n++;
      end
      chk({name, "_done_seen"}, 32'(DONE), 32'd1);
      if (exp_q.size() == 0) chk({name, "_done_within_2"}, 32'(n <= 2), 32'd1);
      START     = 1'b1;  // ignored while BUSY would be high; DONE cycle is IDLE,
      START     = 1'b0;  // so no new request is issued here
      @(negedge CLK);
      @(negedge CLK);
      chk({name, "_done_once"}, 32'(done_cnt), 32'd1);
      chk({name, "_busy_end"}, 32'(BUSY), 32'd0);
      chk({name, "_n_chars"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         chk($sformatf("%s_char%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
      chk({name, "_n_reads"}, 32'(got_addr_q.size()), 32'(exp_addr_q.size()));
      for (int i = 0; i < got_addr_q.size() && i < exp_addr_q.size(); i++)
         chk($sformatf("%s_addr%0d", name, i), 32'(got_addr_q[i]), 32'(exp_addr_q[i]));
   endtask

   task automatic chk_reset_outputs(input string name);
      chk({name, "_tx_valid"}, 32'(TX_VALID), 32'd0);
      chk({name, "_tx_data"}, 32'(TX_DATA), 32'h00);
      chk({name, "_mem_rd"}, 32'(MEM_RD), 32'd0);
      chk({name, "_mem_addr"}, 32'(MEM_ADDR), 32'h0000);
      chk({name, "_busy"}, 32'(BUSY), 32'd0);
      chk({name, "_done"}, 32'(DONE), 32'd0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int n;
      CLR = 1'b1; START = 1'b0; BASE_ADDR = 16'h0000; LENGTH = 16'h0000;
      rmode = 0; rcyc = 0; done_cnt = 0;
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      repeat (3) @(negedge CLK);
      chk_reset_outputs("reset");
      chk("reset_state", 32'(DBG_STATE), 32'd0);
      CLR = 1'b0;
      @(negedge CLK);

      // Three-byte record.
      mem[16'h0100] = 8'h01; mem[16'h0101] = 8'h02; mem[16'h0102] = 8'h03;
      do_xfer("three", 16'h0100, 16'd3, 0);

      // Split into a full record and a partial one.
      for (int i = 0; i < 20; i++) mem[i] = 8'(i);
      do_xfer("split", 16'h0000, 16'd20, 0);

      // Record spanning the top of the address space.
      mem[16'hFFFF] = 8'h00; mem[16'h0000] = 8'h00;
      do_xfer("wrap", 16'hFFFF, 16'd2, 0);
      for (int i = 0; i < 20; i++) mem[i] = 8'(i);

      // Backpressure: fixed 5-cycle stall, then random ready.
      do_xfer("stall5", 16'h0000, 16'd20, 2);
      do_xfer("rand_rdy", 16'h0000, 16'd20, 1);

      // Empty transfer.
      do_xfer("len0", 16'h1234, 16'd0, 0);

      // Abort in the middle of a data character.
      for (int i = 0; i < 5; i++) mem[16'h0200 + i] = 8'($urandom);
      rmode = 0;
      @(negedge CLK);
      START = 1'b1; BASE_ADDR = 16'h0200; LENGTH = 16'd5;
      @(negedge CLK);
      START = 1'b0;
      n = 0;
      while (!MEM_RD && n < 50) begin
         @(negedge CLK);
         n++;
      end
      chk("abort_read_seen", 32'(MEM_RD), 32'd1);
      @(negedge CLK);   // LAT
      @(negedge CLK);   // DH: high-nibble character presented
      chk("abort_in_dh", 32'(TX_VALID), 32'd1);
      CLR = 1'b1;
      #1;
      chk_reset_outputs("abort");
      @(negedge CLK);
      CLR = 1'b0;
      do_xfer("after_abort", 16'h0200, 16'd5, 0);

      // Random transfers.
      for (int t = 0; t < 8; t++) begin
         logic [15:0] b;
         logic [15:0] l;
         b = 16'($urandom);
         l = 16'($urandom_range(0, 40));
         for (int i = 0; i < int'(l); i++) mem[16'(b + i)] = 8'($urandom);
         do_xfer($sformatf("rnd%0d", t), b, l, int'($urandom_range(0, 2)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
